axi_sram_slave: RTL
===================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 slave endpoint downstream of the AXI interconnect; consumes one S-side port (S0/S1) and drives a
//  single-port synchronous SRAM macro (1-cycle read latency, per-byte active-low write enables).
//  Serves one transaction at a time (read or write burst), INCR/FIXED bursts, in-order, no outstanding queue.
// PARAMETERS
//  ID_W      8   AXI ID width (matches interconnect slave-side ID width: master ID + 4-bit tag)
//  SRAM_AW   14  SRAM word-address width; SRAM_A = byte addr[SRAM_AW+1:2]
// PORTS
//  ACLK                                in   1      clock
//  ARESET                              in   1      async reset, active-high
//  AWID/AWADDR/AWLEN/AWSIZE/AWBURST    in   ID_W/32/4/3/2  write address
//  AWVALID in 1 / AWREADY out 1                    write address handshake
//  WDATA/WSTRB/WLAST                   in   32/4/1 write data
//  WVALID in 1 / WREADY out 1                      write data handshake
//  BID/BRESP                           out  ID_W/2 write response
//  BVALID out 1 / BREADY in 1                      write response handshake
//  ARID/ARADDR/ARLEN/ARSIZE/ARBURST    in   ID_W/32/4/3/2  read address
//  ARVALID in 1 / ARREADY out 1                    read address handshake
//  RID/RDATA/RRESP/RLAST               out  ID_W/32/2/1 read data
//  RVALID out 1 / RREADY in 1                      read data handshake
//  SRAM_CS  out 1  chip select; SRAM_OE out 1 read enable; SRAM_WEB out 4 byte write enable, active-low
//  SRAM_A   out SRAM_AW word address; SRAM_DI out 32 write data; SRAM_DO in 32 read data (valid cycle after A)
// BEHAVIOUR
//  Reset: state=IDLE; all *VALID/*READY=0, BRESP/RRESP=0, RLAST=0, RDATA=0, CS=OE=0, WEB=4'hF, rd_turn=0.
//  FSM: IDLE, R_ADDR, R_WAIT, R_DATA, W_DATA, B_RESP. Reset mid-burst -> IDLE, transaction dropped.
//  IDLE: ARREADY = ARVALID & (!AWVALID | rd_turn); AWREADY = AWVALID & (!ARVALID | !rd_turn).
//   Both valid same cycle: rd_turn picks; rd_turn toggles after every accepted address (write wins first).
//   AR hs: latch ID/addr/len/burst, beat cnt=0 -> R_ADDR.  AW hs: latch likewise -> W_DATA.
//  R_ADDR: CS=OE=1, A=cur addr -> R_WAIT.  R_WAIT: CS=OE=1; capture SRAM_DO into rdata_q at edge -> R_DATA.
//  R_DATA: RVALID=1, RDATA=rdata_q, RID=latched, RLAST=(cnt==len); outputs stable while !RREADY.
//   RREADY: last -> IDLE; else cnt++, addr advance -> R_ADDR. First RVALID 3 cycles after AR hs; 3 cyc/beat min.
//  W_DATA: WREADY=1; on WVALID: CS=1, WEB=~WSTRB, A=cur addr, DI=WDATA (same cycle); cnt++, addr advance.
//   WSTRB=0 beat: WEB=4'hF, no byte written, beat still counted. WLAST hs -> B_RESP.
//  B_RESP: BVALID=1, BID=latched, BRESP per CONFIGURATION; hold until BREADY -> IDLE.
//  Addr advance: INCR (2'b01) and WRAP (2'b10, treated as INCR): word addr+1, wraps mod 2^SRAM_AW;
//   FIXED (2'b00): unchanged. Beat count 4 bits; len=15 gives 16 beats.
//  No address decode here: upper ARADDR/AWADDR bits above SRAM_AW+1 ignored.
// CONFIGURATION
//  AXI_SRAM_ERR_CHECK_EN defined: RRESP/BRESP=SLVERR(2'b10) if latched SIZE!=3'b010; BRESP=SLVERR if WLAST
//   arrives at beat !=len. Data still read/written; WLAST alone ends the burst (extra beats accepted/written).
//  Undefined: RRESP=BRESP=OKAY(2'b00) always; no size/length checks, logic removed.
// STRUCTURE
//  Package axi_sram_pkg: state_e enum, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, SIZE_WORD constants.
//  Sub-module axi_sram_addr_gen: latched addr/burst/len, load/advance strobes -> word addr, beat cnt, last flag.
// TESTING
//  Single read: preload mem[0x10]=32'hDEADBEEF; ARADDR=0x40,LEN=0 -> RVALID 3 cyc after hs, RDATA=DEADBEEF, RLAST=1.
//  Write burst: AWADDR=0x100,LEN=3, WSTRB 4'hF,4'h1,4'h0,4'hF -> mem[0x40..0x43] bytes per strobe; BRESP=0, BID echoed.
//  Simultaneous AR+AW after reset -> AW served first, then AR; next collision -> AR first.
//  RREADY held low 5 cycles on beat 2 of LEN=3 read -> RDATA/RLAST stable, no SRAM re-access, 4 beats total.
//  Wrap/FIXED: AWADDR=0xFFFC,LEN=1,INCR -> writes word 0x3FFF then 0x0000; FIXED LEN=2 -> 3 writes same word.
//  ERR_CHECK_EN: AWLEN=3 with WLAST on beat 1 -> BRESP=2'b10; ARSIZE=1 -> RRESP=2'b10; ARESET mid-burst -> IDLE, WEB=F.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4-to-SRAM slave endpoint.
package axi_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R_ADDR,
    R_WAIT,
    R_DATA,
    W_DATA,
    B_RESP
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // WRAP bursts step like INCR; FIXED (and the reserved encoding) hold the address.
  function automatic logic burst_advances(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_sram_addr_gen.sv
// Burst address generator: holds the word address, burst type and length of
// the active transaction and steps them one beat at a time.
module axi_sram_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [SRAM_AW-1:0] start_addr,
  input  logic [1:0]         start_burst,
  input  logic [3:0]         start_len,
  output logic [SRAM_AW-1:0] word_addr,
  output logic [3:0]         beat_cnt,
  output logic               last
);

  logic [1:0] burst_q;
  logic [3:0] len_q;

  // Latch a new burst on load, otherwise step count and address per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_addr <= '0;
      beat_cnt  <= '0;
      burst_q   <= BURST_FIXED;
      len_q     <= '0;
    end else if (load) begin
      word_addr <= start_addr;
      beat_cnt  <= '0;
      burst_q   <= start_burst;
      len_q     <= start_len;
    end else if (advance) begin
      beat_cnt <= beat_cnt + 4'd1;
      if (burst_advances(burst_q)) begin
        word_addr <= word_addr + SRAM_AW'(1);
      end
    end
  end

  assign last = (beat_cnt == len_q);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave endpoint driving a single-port synchronous SRAM (1-cycle read
// latency, active-low byte write enables). One transaction at a time.
// Optional build macro AXI_SRAM_ERR_CHECK_EN adds SLVERR reporting for
// non-word transfer sizes and WLAST/length mismatches.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int unsigned ID_W    = 8,
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [ID_W-1:0]    AWID,
  input  logic [31:0]        AWADDR,
  input  logic [3:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [ID_W-1:0]    BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [ID_W-1:0]    ARID,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_W-1:0]    RID,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               SRAM_CS,
  output logic               SRAM_OE,
  output logic [3:0]         SRAM_WEB,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic [31:0]        SRAM_DI,
  input  logic [31:0]        SRAM_DO
);

  state_e              state, state_n;
  logic                rd_turn;
  logic [ID_W-1:0]     id_q;
  logic [31:0]         rdata_q;
  logic                take_aw, take_ar, load, advance, last;
  logic [SRAM_AW-1:0]  word_addr;
  logic [3:0]          beat_cnt;
  logic [1:0]          rresp_v, bresp_v;

  // Round-robin between channels only matters when both are valid together.
  assign take_aw = (state == IDLE) && AWVALID && (!ARVALID || !rd_turn);
  assign take_ar = (state == IDLE) && ARVALID && (!AWVALID ||  rd_turn);
  assign load    = take_aw || take_ar;

  axi_sram_addr_gen #(
    .SRAM_AW(SRAM_AW)
  ) u_addr_gen (
    .clk        (ACLK),
    .rst        (ARESET),
    .load       (load),
    .advance    (advance),
    .start_addr (take_aw ? AWADDR[SRAM_AW+1:2] : ARADDR[SRAM_AW+1:2]),
    .start_burst(take_aw ? AWBURST : ARBURST),
    .start_len  (take_aw ? AWLEN : ARLEN),
    .word_addr  (word_addr),
    .beat_cnt   (beat_cnt),
    .last       (last)
  );

  // State register, arbitration toggle, ID latch and read-data capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      rd_turn <= 1'b0;
      id_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        rd_turn <= ~rd_turn;
        id_q    <= take_aw ? AWID : ARID;
      end
      if (state == R_WAIT) begin
        rdata_q <= SRAM_DO;
      end
    end
  end

`ifdef AXI_SRAM_ERR_CHECK_EN
  logic [2:0] size_q;
  logic       werr_q;

  // Remember transfer size and flag a WLAST that disagrees with the burst length.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      size_q <= SIZE_WORD;
      werr_q <= 1'b0;
    end else if (load) begin
      size_q <= take_aw ? AWSIZE : ARSIZE;
      werr_q <= 1'b0;
    end else if ((state == W_DATA) && WVALID && WLAST && !last) begin
      werr_q <= 1'b1;
    end
  end

  assign rresp_v = (size_q != SIZE_WORD) ? RESP_SLVERR : RESP_OKAY;
  assign bresp_v = ((size_q != SIZE_WORD) || werr_q) ? RESP_SLVERR : RESP_OKAY;

  logic unused_ok;
  assign unused_ok = ^{AWADDR[31:SRAM_AW+2], AWADDR[1:0], ARADDR[31:SRAM_AW+2],
                       ARADDR[1:0], beat_cnt};
`else
  assign rresp_v = RESP_OKAY;
  assign bresp_v = RESP_OKAY;

  logic unused_ok;
  assign unused_ok = ^{AWADDR[31:SRAM_AW+2], AWADDR[1:0], ARADDR[31:SRAM_AW+2],
                       ARADDR[1:0], beat_cnt, AWSIZE, ARSIZE};
`endif

  assign RID     = id_q;
  assign BID     = id_q;
  assign RDATA   = rdata_q;
  assign SRAM_A  = word_addr;
  assign SRAM_DI = WDATA;

  // Next-state, handshake and SRAM strobe decode.
  always_comb begin
    state_n  = state;
    AWREADY  = 1'b0;
    ARREADY  = 1'b0;
    WREADY   = 1'b0;
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    RRESP    = RESP_OKAY;
    BVALID   = 1'b0;
    BRESP    = RESP_OKAY;
    SRAM_CS  = 1'b0;
    SRAM_OE  = 1'b0;
    SRAM_WEB = '1;
    advance  = 1'b0;
    unique case (state)
      IDLE: begin
        AWREADY = take_aw;
        ARREADY = take_ar;
        if (take_aw) begin
          state_n = W_DATA;
        end else if (take_ar) begin
          state_n = R_ADDR;
        end
      end
      R_ADDR: begin
        SRAM_CS = 1'b1;
        SRAM_OE = 1'b1;
        state_n = R_WAIT;
      end
      R_WAIT: begin
        SRAM_CS = 1'b1;
        SRAM_OE = 1'b1;
        state_n = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = last;
        RRESP  = rresp_v;
        if (RREADY) begin
          if (last) begin
            state_n = IDLE;
          end else begin
            advance = 1'b1;
            state_n = R_ADDR;
          end
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          SRAM_CS  = 1'b1;
          SRAM_WEB = ~WSTRB;
          advance  = 1'b1;
          if (WLAST) begin
            state_n = B_RESP;
          end
        end
      end
      B_RESP: begin
        BVALID = 1'b1;
        BRESP  = bresp_v;
        if (BREADY) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
